// File: rtl/cook_timer_if.sv
// Cook-timer bus: keypad/control strobes in, display digits and status out.
// The master side (control panel) drives the strobes; the timer is the slave.
interface cook_timer_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       start;
    logic       stop;
    logic       door_open;
    logic       tick;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       mag_on;
    logic       done;
    logic       beep;
    logic [1:0] state;

    modport master (
        output digit, digit_valid, start, stop, door_open, tick,
        input  min_t, min_o, sec_t, sec_o, mag_on, done, beep, state
    );

    modport slave (
        input  digit, digit_valid, start, stop, door_open, tick,
        output min_t, min_o, sec_t, sec_o, mag_on, done, beep, state
    );
endinterface

// File: rtl/cook_timer.sv
// Microwave cook-time entry and countdown.
// Digits shift in as MM:SS, count down once per 1 Hz tick while running,
// pause on door open or stop, and pulse done at 00:00.
// Optional completion beeper is built only when COOK_BEEP_EN is defined;
// it stays high for BEEP_TICKS ticks after reaching 00:00.
module cook_timer #(
    parameter int BEEP_TICKS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    cook_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A negative beep length has no meaning; refuse it at elaboration.
    if (BEEP_TICKS < 0) begin : g_bad_cfg
        $error("cook_timer: BEEP_TICKS must be >= 0");
    end

    state_t     st;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       mag_on;
    logic       done;

    logic [3:0] din;
    logic [3:0] dmin_t, dmin_o, dsec_t, dsec_o;
    logic       reg_zero;
    logic       dec_zero;
    logic       go_done;
    logic       leave_done;

    // Clamp the key digit and precompute the one-second BCD decrement.
    // Seconds tens always wraps to 5 after a borrow, but a keyed-in value
    // above 5 simply counts down from where it is.
    always_comb begin
        din    = (bus.digit > 4'd9) ? 4'd9 : bus.digit;
        dsec_o = sec_o - 4'd1;
        dsec_t = sec_t;
        dmin_o = min_o;
        dmin_t = min_t;
        if (sec_o == 4'd0) begin
            dsec_o = 4'd9;
            if (sec_t != 4'd0) begin
                dsec_t = sec_t - 4'd1;
            end else begin
                dsec_t = 4'd5;
                if (min_o != 4'd0) begin
                    dmin_o = min_o - 4'd1;
                end else begin
                    dmin_o = 4'd9;
                    dmin_t = min_t - 4'd1;
                end
            end
        end
        reg_zero   = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
        dec_zero   = ({dmin_t, dmin_o, dsec_t, dsec_o} == 16'h0000);
        // Final tick: only when no higher-priority pause request is present.
        go_done    = (st == RUN) && !bus.stop && !bus.door_open && bus.tick && dec_zero;
        leave_done = (st == DONE) && (bus.digit_valid || bus.start || bus.stop);
    end

    // Main FSM with registered digits, magnetron enable and done pulse.
    // Priority inside each state: stop > door_open > start > tick > digit_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            min_t  <= 4'd0;
            min_o  <= 4'd0;
            sec_t  <= 4'd0;
            sec_o  <= 4'd0;
            mag_on <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (bus.stop) begin
                        min_t <= 4'd0;
                        min_o <= 4'd0;
                        sec_t <= 4'd0;
                        sec_o <= 4'd0;
                    end else if (bus.start && !bus.door_open && !reg_zero) begin
                        st     <= RUN;
                        mag_on <= 1'b1;
                    end else if (bus.digit_valid) begin
                        min_t <= min_o;
                        min_o <= sec_t;
                        sec_t <= sec_o;
                        sec_o <= din;
                    end
                end
                RUN: begin
                    // A tick arriving with the pause request is dropped.
                    if (bus.stop || bus.door_open) begin
                        st     <= PAUSE;
                        mag_on <= 1'b0;
                    end else if (bus.tick) begin
                        min_t <= dmin_t;
                        min_o <= dmin_o;
                        sec_t <= dsec_t;
                        sec_o <= dsec_o;
                        if (go_done) begin
                            st     <= DONE;
                            mag_on <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        st    <= IDLE;
                        min_t <= 4'd0;
                        min_o <= 4'd0;
                        sec_t <= 4'd0;
                        sec_o <= 4'd0;
                    end else if (bus.start && !bus.door_open) begin
                        st     <= RUN;
                        mag_on <= 1'b1;
                    end
                end
                DONE: begin
                    // Digits are already 00:00; a key press lands as the first digit.
                    if (leave_done) begin
                        st <= IDLE;
                        if (bus.digit_valid && !bus.stop) begin
                            min_t <= min_o;
                            min_o <= sec_t;
                            sec_t <= sec_o;
                            sec_o <= din;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef COOK_BEEP_EN
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

    logic          beep;
    logic [BW-1:0] beep_cnt;

    // Beeper: armed on entry to DONE, counts ticks down, cleared on leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (go_done) begin
            beep     <= (BEEP_TICKS != 0);
            beep_cnt <= BW'(BEEP_TICKS);
        end else if (leave_done) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (beep && bus.tick) begin
            beep_cnt <= beep_cnt - BW'(1);
            if (beep_cnt == BW'(1)) beep <= 1'b0;
        end
    end

    assign bus.beep = beep;
`else
    assign bus.beep = 1'b0;
`endif

    assign bus.state  = st;
    assign bus.min_t  = min_t;
    assign bus.min_o  = min_o;
    assign bus.sec_t  = sec_t;
    assign bus.sec_o  = sec_o;
    assign bus.mag_on = mag_on;
    assign bus.done   = done;

endmodule
